// File: rtl/mac_pkg.sv
// Shared constants and types for the multiply-accumulate result path.
package mac_pkg;

   localparam int unsigned RESULT_W  = 16;
   localparam int unsigned SUM_W_DEF = 32;

   typedef logic [RESULT_W-1:0]  result_t;
   typedef logic [SUM_W_DEF-1:0] sum_t;

endpackage

// File: rtl/mac_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array, synchronous write, combinational read.
module mac_fifo_mem #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write the pushed word; storage needs no reset since pointers gate visibility.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mac_result_fifo.sv
// First-word-fall-through result FIFO with running sum of popped words.
// Optional build macro MAC_RESULT_FIFO_STATS_EN adds stall/push counters.
module mac_result_fifo
   import mac_pkg::*;
#(
   parameter int unsigned WIDTH = RESULT_W,
   parameter int unsigned DEPTH = 8,          // power of two, >= 2
   parameter int unsigned SUM_W = SUM_W_DEF,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             sum_clr,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic [SUM_W-1:0] run_sum
`ifdef MAC_RESULT_FIFO_STATS_EN
   ,
   output logic [15:0]      stall_cnt,
   output logic [15:0]      push_cnt
`endif
);

   localparam int unsigned AW = CNT_W - 1;

   // Pointers carry one extra MSB so a full wrap is distinguishable from empty.
   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic             push, pop;

   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign count = wr_ptr_q - rd_ptr_q;

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   mac_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (in_data),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (out_data)
   );

   // Next-state for pointers and running sum; a clear coinciding with a pop keeps the popped word.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      sum_d    = sum_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (sum_clr) begin
         sum_d = pop ? SUM_W'(out_data) : '0;
      end else if (pop) begin
         sum_d = sum_q + SUM_W'(out_data);
      end
   end

   // State registers; reset discards all stored words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         sum_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         sum_q    <= sum_d;
      end
   end

   assign run_sum = sum_q;

`ifdef MAC_RESULT_FIFO_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] push_cnt_q, push_cnt_d;

   // Saturating statistics counters, cleared together with the running sum.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      push_cnt_d  = push_cnt_q;
      if (sum_clr) begin
         stall_cnt_d = '0;
         push_cnt_d  = '0;
      end else begin
         if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
         end
         if (push && (push_cnt_q != 16'hFFFF)) begin
            push_cnt_d = push_cnt_q + 16'd1;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         push_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         push_cnt_q  <= push_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign push_cnt  = push_cnt_q;
`endif

endmodule

// File: tb/tb_mac_result_fifo.sv
// Self-checking bench for mac_result_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_mac_result_fifo;
   import mac_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   result_t     in_data;
   logic        in_valid;
   logic        in_ready;
   result_t     out_data;
   logic        out_valid;
   logic        out_ready;
   logic        sum_clr;
   logic [3:0]  count;
   logic        full;
   logic        empty;
   sum_t        run_sum;
`ifdef MAC_RESULT_FIFO_STATS_EN
   logic [15:0] stall_cnt;
   logic [15:0] push_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model
   result_t mq[$];
   sum_t    m_sum;
   int      m_stall;
   int      m_push;

   always #5 clk = ~clk;

   mac_result_fifo u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum_clr   (sum_clr),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .run_sum   (run_sum)
`ifdef MAC_RESULT_FIFO_STATS_EN
      ,
      .stall_cnt (stall_cnt),
      .push_cnt  (push_cnt)
`endif
   );

   task automatic model_clear();
      mq.delete();
      m_sum   = '0;
      m_stall = 0;
      m_push  = 0;
   endtask

   // Advance one clock from a negedge to the next, updating the model from the inputs.
   task automatic tick();
      bit      do_push, do_pop, stall, clr;
      result_t pv, din;
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() != 0);
      stall   = in_valid && (mq.size() == DEPTH);
      clr     = sum_clr;
      din     = in_data;
      pv      = do_pop ? mq[0] : '0;
      @(posedge clk);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(din);
      m_sum = clr ? sum_t'(pv) : m_sum + sum_t'(pv);
      if (clr) begin
         m_stall = 0;
         m_push  = 0;
      end else begin
         if (stall && m_stall < 65535) m_stall++;
         if (do_push && m_push < 65535) m_push++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sum_clr = 1'b0; in_data = '0;
      repeat (2) @(negedge clk);
      total++;
      if (empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: got empty=%b full=%b in_ready=%b out_valid=%b, want 1 0 1 0",
                  empty, full, in_ready, out_valid);
      end
      total++;
      if (count !== 4'd0 || run_sum !== 32'd0) begin
         bad++;
         $display("FAIL reset_state: got count=%0d run_sum=%0d, want 0 0", count, run_sum);
      end
      reset = 1'b1;
      model_clear();
      repeat (2) @(negedge clk);
      total++;
      if (empty !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 4'd0 ||
          run_sum !== 32'd0) begin
         bad++;
         $display("FAIL idle_after_reset: got empty=%b in_ready=%b out_valid=%b count=%0d sum=%0d",
                  empty, in_ready, out_valid, count, run_sum);
      end
   endtask

   task automatic test_order();
      result_t exp_v [3] = '{16'd3, 16'd5, 16'd7};
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = exp_v[i];
         tick();
      end
      in_valid = 1'b0;
      total++;
      if (count !== 4'd3 || out_data !== 16'd3 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL order_fill: got count=%0d out_data=%0d out_valid=%b, want 3 3 1",
                  count, out_data, out_valid);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== exp_v[i]) begin
            bad++;
            $display("FAIL order_pop%0d: got valid=%b data=%0d, want 1 %0d",
                     i, out_valid, out_data, exp_v[i]);
         end
         tick();
      end
      out_ready = 1'b0;
      total++;
      if (run_sum !== 32'd15 || empty !== 1'b1) begin
         bad++;
         $display("FAIL order_sum: got run_sum=%0d empty=%b, want 15 1", run_sum, empty);
      end
   endtask

   task automatic test_full();
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = result_t'(i);
         tick();
      end
      in_data = 16'd9;
      tick();
      total++;
      if (full !== 1'b1 || in_ready !== 1'b0 || count !== 4'd8 || out_data !== 16'd1) begin
         bad++;
         $display("FAIL full_hold: got full=%b in_ready=%b count=%0d head=%0d, want 1 0 8 1",
                  full, in_ready, count, out_data);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || count !== 4'd7 || full !== 1'b0) begin
         bad++;
         $display("FAIL full_pop: got in_ready=%b count=%0d full=%b, want 1 7 0",
                  in_ready, count, full);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if (count !== 4'd8 || full !== 1'b1) begin
         bad++;
         $display("FAIL full_refill: got count=%0d full=%b, want 8 1", count, full);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (out_data !== result_t'(i + 2)) begin
            bad++;
            $display("FAIL full_drain%0d: got %0d want %0d", i, out_data, i + 2);
         end
         tick();
      end
      out_ready = 1'b0;
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL full_empty: got empty=%b want 1", empty);
      end
   endtask

   task automatic test_back_to_back();
      sum_clr = 1'b1;
      tick();
      sum_clr = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i <= 20; i++) begin
         in_valid = (i < 20);
         in_data  = result_t'(100 + i);
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stream_stall%0d: got in_ready=%b want 1", i, in_ready);
         end
         if (i > 0) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== result_t'(99 + i)) begin
               bad++;
               $display("FAIL stream_data%0d: got valid=%b data=%0d, want 1 %0d",
                        i, out_valid, out_data, 99 + i);
            end
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      total++;
      if (run_sum !== 32'd2190 || empty !== 1'b1) begin
         bad++;
         $display("FAIL stream_sum: got run_sum=%0d empty=%b, want 2190 1", run_sum, empty);
      end
   endtask

   task automatic test_sum_clr();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'hFFFF;
      tick();
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1; sum_clr = 1'b1;
      tick();
      sum_clr = 1'b0;
      total++;
      if (run_sum !== 32'h0000_FFFF) begin
         bad++;
         $display("FAIL clr_with_pop: got run_sum=%h want 0000ffff", run_sum);
      end
      tick();
      out_ready = 1'b0;
      total++;
      if (run_sum !== 32'h0001_FFFE) begin
         bad++;
         $display("FAIL clr_second_pop: got run_sum=%h want 0001fffe", run_sum);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         // Bias push/pop rates per phase so both full and empty are visited.
         in_valid  = ($urandom_range(0, 3) < ((c / 100) % 2 == 0 ? 3 : 1));
         out_ready = ($urandom_range(0, 3) < ((c / 100) % 2 == 0 ? 1 : 3));
         sum_clr   = ($urandom_range(0, 29) == 0);
         in_data   = result_t'($urandom);
         total++;
         if (count !== 4'(mq.size()) || full !== (mq.size() == DEPTH) ||
             empty !== (mq.size() == 0) || in_ready !== (mq.size() != DEPTH) ||
             out_valid !== (mq.size() != 0)) begin
            bad++;
            $display("FAIL rand_flags@%0d: got count=%0d full=%b empty=%b, want count=%0d",
                     c, count, full, empty, mq.size());
         end
         if (mq.size() != 0) begin
            total++;
            if (out_data !== mq[0]) begin
               bad++;
               $display("FAIL rand_data@%0d: got %h want %h", c, out_data, mq[0]);
            end
         end
         total++;
         if (run_sum !== m_sum) begin
            bad++;
            $display("FAIL rand_sum@%0d: got %h want %h", c, run_sum, m_sum);
         end
`ifdef MAC_RESULT_FIFO_STATS_EN
         total++;
         if (stall_cnt !== 16'(m_stall) || push_cnt !== 16'(m_push)) begin
            bad++;
            $display("FAIL rand_stats@%0d: got stall=%0d push=%0d want %0d %0d",
                     c, stall_cnt, push_cnt, m_stall, m_push);
         end
`endif
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b0; sum_clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = result_t'($urandom);
         tick();
      end
      in_valid = 1'b0;
      total++;
      if (count !== 4'd4) begin
         bad++;
         $display("FAIL mid_prefill: got count=%0d want 4", count);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || empty !== 1'b1) begin
         bad++;
         $display("FAIL mid_async: got count=%0d out_valid=%b in_ready=%b empty=%b, want 0 0 1 1",
                  count, out_valid, in_ready, empty);
      end
`ifdef MAC_RESULT_FIFO_STATS_EN
      total++;
      if (stall_cnt !== 16'd0 || push_cnt !== 16'd0) begin
         bad++;
         $display("FAIL mid_stats: got stall=%0d push=%0d want 0 0", stall_cnt, push_cnt);
      end
`endif
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (count !== 4'd0 || out_valid !== 1'b0 || run_sum !== 32'd0) begin
         bad++;
         $display("FAIL mid_restart: got count=%0d out_valid=%b sum=%0d, want 0 0 0",
                  count, out_valid, run_sum);
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_full();
      test_back_to_back();
      test_sum_clr();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_result_fifo.md
Name: mac_result_fifo

Overview:
Downstream consumer of the multiply-accumulate pipeline's result stream.
- Buffers 16-bit results in a first-word-fall-through FIFO and re-presents them to the next consumer over ready/valid.
- Keeps a running sum of every result popped.
- Drives the pipeline's ready_in, so a downstream stall back-pressures the pipeline instead of losing results.

Parameters:
WIDTH, 16, data width of each result entry
DEPTH, 8, number of FIFO entries; must be a power of two and at least 2
SUM_W, 32, width of the running-sum accumulator
CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden)

Ports:
clk  input  1  single clock, rising-edge
reset  input  1  asynchronous, active-low reset
in_data  input  WIDTH  result word from the pipeline
in_valid  input  1  pipeline valid_out
in_ready  output  1  to the pipeline ready_in; high when a push can be accepted
out_data  output  WIDTH  head-of-FIFO word
out_valid  output  1  head word is valid
out_ready  input  1  downstream consumer ready
sum_clr  input  1  synchronous clear of the running sum
count  output  CNT_W  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
run_sum  output  SUM_W  sum of all popped words since the last reset or clear

Behaviour:
- Reset is asynchronous and active-low. While reset = 0:
  - read and write pointers = 0, count = 0, run_sum = 0
  - empty = 1, full = 0, in_ready = 1, out_valid = 0
  - out_data = don't-care; verification must not check it while out_valid = 0
- Push occurs when in_valid && in_ready. The word is written at wr_ptr and wr_ptr increments.
- Pop occurs when out_valid && out_ready. rd_ptr increments.
- Pointers are log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty on wrap-around.
- Flags:
  - full when the pointer LSBs are equal and the MSBs differ
  - empty when the pointers are fully equal
- in_ready = !full, combinational from registered state and independent of out_ready. There is no same-cycle pass-through when full: a push while full is never accepted.
- out_valid = !empty. out_data = mem[rd_ptr], combinational read (first-word fall-through).
- Latency: a word pushed in cycle N is visible on out_data/out_valid in cycle N+1. Minimum push-to-pop latency is 1 cycle.
- Simultaneous push and pop (neither full nor empty): count is unchanged and both pointers advance.
- Empty with push and out_ready both high: only the push takes effect, because out_valid = 0 in that cycle.
- Full with a pop and in_valid high: only the pop takes effect. in_ready rises in the next cycle.
- count increments on push-only, decrements on pop-only, and holds otherwise.
- Running sum:
  - On a pop, run_sum <= run_sum + zero-extended out_data, wrapping modulo 2^SUM_W.
  - sum_clr has priority: with sum_clr and no pop, run_sum <= 0; with sum_clr and a pop in the same cycle, run_sum <= the popped word.
- Reset asserted mid-operation discards all stored words immediately; the FIFO restarts empty.
- out_data stability: while out_valid = 1 and out_ready = 0, out_data holds its value.

Optional Feature:
Macro MAC_RESULT_FIFO_STATS_EN.
- Defined: adds two outputs.
  - stall_cnt[15:0]: counts cycles with in_valid && !in_ready.
  - push_cnt[15:0]: counts accepted pushes.
  - Both saturate at 16'hFFFF, reset to 0, and clear on sum_clr.
- Not defined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package mac_pkg holds:
  - the constants RESULT_W = 16 and SUM_W_DEF = 32
  - the typedef result_t (logic [RESULT_W-1:0])
  - the typedef sum_t
- One natural sub-module, mac_fifo_mem: the DEPTH x WIDTH register array with a synchronous write port and a combinational read port.
- Pointer, flag, and sum logic stay in the top module.

Test Plan:
- Reset then idle: after reset is released, expect empty = 1, in_ready = 1, out_valid = 0, count = 0, run_sum = 0.
- Push 3, 5, 7 back-to-back with out_ready = 0: expect count = 3 and out_data = 3. Then hold out_ready = 1 for 3 cycles: expect pops of 3, 5, 7 in order and run_sum = 15.
- Fill to DEPTH = 8 with values 1..8 and keep in_valid = 1: expect full = 1, in_ready = 0, and the 9th word held off. Pop once: expect in_ready = 1 in the next cycle, the 9th word accepted, and count back at 8.
- Continuous push and pop of 20 words (values 100..119) with out_ready = 1: expect no stall after the first cycle, pointer wrap exercised, out_data in order, and run_sum = 2190.
- Push 0xFFFF twice, then pop the first word with sum_clr asserted in the same cycle: expect run_sum = 0xFFFF. Pop the second word: expect run_sum = 0x1FFFE.
- Push 4 words, assert reset mid-stream: expect count = 0, out_valid = 0, in_ready = 1 asynchronously. With MAC_RESULT_FIFO_STATS_EN defined, stall_cnt and push_cnt also read 0.
